// File: rtl/wr_buffer.sv
// wr_buffer: write-side staging FIFO that releases data to wr_master one
// full burst at a time, with burst start addresses that walk a circular window.
module wr_buffer #(
  parameter int                        AXI_ADDR_WIDTH = 32,
  parameter int                        AXI_DATA_WIDTH = 128,
  parameter int                        BURST_LEN      = 64,
  parameter int                        FIFO_DEPTH     = 512,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR      = 32'h0000_0000,
  parameter logic [AXI_ADDR_WIDTH-1:0] ADDR_RANGE     = 32'h0010_0000
) (
  input  logic                          axi_clk,
  input  logic                          reset,
  input  logic                          user_wr_valid,
  output logic                          user_wr_ready,
  input  logic [AXI_DATA_WIDTH-1:0]     user_wr_data,
  output logic                          axi_aw_req_en,
  input  logic                          axi_aw_ready,
  output logic [7:0]                    axi_aw_burst_len,
  output logic [AXI_ADDR_WIDTH-1:0]     axi_aw_addr,
  output logic                          axi_w_valid,
  input  logic                          axi_w_ready,
  output logic [AXI_DATA_WIDTH-1:0]     axi_w_data,
  output logic                          axi_w_last,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          burst_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]          FULL_CNT    = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]          BURST_CNT   = CNT_W'(BURST_LEN);
  localparam logic [7:0]                LAST_BEAT   = 8'(BURST_LEN - 1);
  localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(BURST_LEN * (AXI_DATA_WIDTH / 8));
  localparam logic [AXI_ADDR_WIDTH-1:0] WIN_END     = AXI_ADDR_WIDTH'(BASE_ADDR + ADDR_RANGE);

  typedef enum logic [1:0] {ST_IDLE, ST_AW_REQ, ST_W_DATA} state_t;

  // FIFO storage and bookkeeping
  logic [AXI_DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          r_wr_ptr;
  logic [PTR_W-1:0]          r_rd_ptr;
  logic [CNT_W-1:0]          r_count;
  logic [AXI_DATA_WIDTH-1:0] r_w_data;

  // control path
  state_t                    r_state;
  logic                      r_aw_req_en;
  logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
  logic                      r_w_valid;
  logic                      r_w_last;
  logic [7:0]                r_beat_cnt;
  logic                      r_burst_done;

  logic                      w_full;
  logic                      w_push;
  logic                      w_pop;
  logic [PTR_W-1:0]          w_rd_ptr_nxt;
  logic [CNT_W-1:0]          w_cnt_after_pop;
  logic [AXI_DATA_WIDTH-1:0] w_head_nxt;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_inc;
  logic [AXI_ADDR_WIDTH-1:0] w_addr_nxt;

  assign w_full = (r_count == FULL_CNT);
  assign w_push = user_wr_valid && !w_full;
  assign w_pop  = r_w_valid && axi_w_ready;

  assign w_addr_inc = r_aw_addr + BURST_BYTES;
  assign w_addr_nxt = (w_addr_inc >= WIN_END) ? BASE_ADDR : w_addr_inc;

  // Next head word: bypass the incoming word when the FIFO would otherwise be
  // empty, otherwise read the entry the read pointer will point at; hold when empty.
  always_comb begin
    w_rd_ptr_nxt    = r_rd_ptr;
    w_cnt_after_pop = r_count;
    w_head_nxt      = r_w_data;
    if (w_pop) begin
      w_rd_ptr_nxt    = r_rd_ptr + PTR_W'(1);
      w_cnt_after_pop = r_count - CNT_W'(1);
    end else begin
      w_rd_ptr_nxt    = r_rd_ptr;
      w_cnt_after_pop = r_count;
    end
    if (w_cnt_after_pop != '0) begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end else if (w_push) begin
      w_head_nxt = user_wr_data;
    end else begin
      w_head_nxt = r_w_data;
    end
  end

  // Storage write; contents are deliberately left unreset.
  always_ff @(posedge axi_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= user_wr_data;
    end
  end

  // FIFO pointers, occupancy and the registered head word.
  always_ff @(posedge axi_clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_w_data <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      r_rd_ptr <= w_rd_ptr_nxt;
      r_w_data <= w_head_nxt;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Burst sequencer: wait for a full burst, request it, then stream it out.
  always_ff @(posedge axi_clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_aw_req_en  <= 1'b0;
      r_aw_addr    <= BASE_ADDR;
      r_w_valid    <= 1'b0;
      r_w_last     <= 1'b0;
      r_beat_cnt   <= 8'd0;
      r_burst_done <= 1'b0;
    end else begin
      r_burst_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_count >= BURST_CNT) begin
            r_state     <= ST_AW_REQ;
            r_aw_req_en <= 1'b1;
          end
        end
        ST_AW_REQ: begin
          if (r_aw_req_en && axi_aw_ready) begin
            r_aw_req_en <= 1'b0;
            r_aw_addr   <= w_addr_nxt;
            r_state     <= ST_W_DATA;
            r_w_valid   <= 1'b1;
            r_beat_cnt  <= 8'd0;
            r_w_last    <= (LAST_BEAT == 8'd0);
          end
        end
        ST_W_DATA: begin
          if (w_pop) begin
            if (r_w_last) begin
              r_state      <= ST_IDLE;
              r_w_valid    <= 1'b0;
              r_w_last     <= 1'b0;
              r_beat_cnt   <= 8'd0;
              r_burst_done <= 1'b1;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
              r_w_last   <= ((r_beat_cnt + 8'd1) == LAST_BEAT);
            end
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_aw_req_en <= 1'b0;
          r_w_valid   <= 1'b0;
          r_w_last    <= 1'b0;
          r_beat_cnt  <= 8'd0;
        end
      endcase
    end
  end

  assign user_wr_ready    = !w_full;
  assign axi_aw_req_en    = r_aw_req_en;
  assign axi_aw_burst_len = LAST_BEAT;
  assign axi_aw_addr      = r_aw_addr;
  assign axi_w_valid      = r_w_valid;
  assign axi_w_data       = r_w_data;
  assign axi_w_last       = r_w_last;
  assign fifo_count       = r_count;
  assign burst_done       = r_burst_done;

endmodule

// File: tb/tb_wr_buffer.sv
// Self-checking bench for wr_buffer: scripted scenarios plus random traffic,
// all compared every cycle against a queue-based behavioural model.
module tb_wr_buffer;

  localparam int          DW    = 128;
  localparam int          BL    = 4;
  localparam int          FD    = 16;
  localparam logic [31:0] BASE  = 32'h1000;
  localparam logic [31:0] RANGE = 32'h100;

  logic          axi_clk = 1'b0;
  logic          reset = 1'b0;
  logic          user_wr_valid = 1'b0;
  logic          user_wr_ready;
  logic [DW-1:0] user_wr_data = '0;
  logic          axi_aw_req_en;
  logic          axi_aw_ready = 1'b0;
  logic [7:0]    axi_aw_burst_len;
  logic [31:0]   axi_aw_addr;
  logic          axi_w_valid;
  logic          axi_w_ready = 1'b0;
  logic [DW-1:0] axi_w_data;
  logic          axi_w_last;
  logic [4:0]    fifo_count;
  logic          burst_done;

  wr_buffer #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(DW), .BURST_LEN(BL), .FIFO_DEPTH(FD),
    .BASE_ADDR(BASE), .ADDR_RANGE(RANGE)
  ) dut (
    .axi_clk(axi_clk), .reset(reset),
    .user_wr_valid(user_wr_valid), .user_wr_ready(user_wr_ready), .user_wr_data(user_wr_data),
    .axi_aw_req_en(axi_aw_req_en), .axi_aw_ready(axi_aw_ready),
    .axi_aw_burst_len(axi_aw_burst_len), .axi_aw_addr(axi_aw_addr),
    .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
    .axi_w_last(axi_w_last), .fifo_count(fifo_count), .burst_done(burst_done)
  );

  always #5 axi_clk = ~axi_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq[$];
  bit            m_req = 1'b0;
  bit            m_wvalid = 1'b0;
  bit            m_done = 1'b0;
  int            m_beats = 0;
  logic [31:0]   m_addr = BASE;
  logic [DW-1:0] m_data = '0;
  int            next_val = 1;
  bit            mp_push, mp_pop;

  // Model: a burst is reserved once BL words wait, requested, then drained in order.
  always @(posedge axi_clk or negedge reset) begin
    if (!reset) begin
      mq.delete();
      m_req = 1'b0; m_wvalid = 1'b0; m_done = 1'b0; m_beats = 0;
      m_addr = BASE; m_data = '0;
    end else begin
      mp_push = user_wr_valid && (mq.size() < FD);
      mp_pop  = m_wvalid && axi_w_ready;
      m_done  = 1'b0;
      if (m_wvalid) begin
        if (mp_pop) begin
          if (m_beats == BL - 1) begin
            m_wvalid = 1'b0; m_beats = 0; m_done = 1'b1;
          end else begin
            m_beats++;
          end
        end
      end else if (m_req) begin
        if (axi_aw_ready) begin
          m_req = 1'b0; m_wvalid = 1'b1; m_beats = 0;
          m_addr = m_addr + 32'(BL * DW / 8);
          if (m_addr >= BASE + RANGE) m_addr = BASE;
        end
      end else if (mq.size() >= BL) begin
        m_req = 1'b1;
      end
      if (mp_pop) void'(mq.pop_front());
      if (mp_push) begin
        mq.push_back(user_wr_data);
        next_val++;
      end
      if (mq.size() != 0) m_data = mq[0];
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(posedge axi_clk) begin
    #1;
    chk("ready", user_wr_ready, (mq.size() < FD));
    chk("count", fifo_count, mq.size());
    chk("aw_req_en", axi_aw_req_en, m_req);
    chk("aw_addr", axi_aw_addr, m_addr);
    chk("burst_len", axi_aw_burst_len, 8'd3);
    chk("w_valid", axi_w_valid, m_wvalid);
    chk("w_last", axi_w_last, (m_wvalid && m_beats == BL - 1));
    chk("burst_done", burst_done, m_done);
    chk("w_data", axi_w_data, m_data);
  end

  // wr_master stand-in: answer a request at least two cycles after it rises.
  int req_age = 0;
  int aw_extra = 0;
  always @(negedge axi_clk) begin
    if (!reset || !axi_aw_req_en) begin
      req_age = 0;
      axi_aw_ready = 1'b0;
      aw_extra = $urandom_range(0, 2);
    end else begin
      req_age++;
      axi_aw_ready = (req_age >= 2 + aw_extra);
    end
  end

  // Log the address of every AW handshake.
  logic [31:0] aw_log[$];
  always @(negedge axi_clk) begin
    #2;
    if (reset && axi_aw_req_en && axi_aw_ready) aw_log.push_back(axi_aw_addr);
  end

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      user_wr_valid = 1'b1;
      user_wr_data  = DW'(next_val);
      @(negedge axi_clk);
    end
    user_wr_valid = 1'b0;
  endtask

  task automatic wait_wvalid(input string name);
    int t;
    t = 0;
    while (!axi_w_valid && t < 40) begin
      @(negedge axi_clk);
      t++;
    end
    chk(name, axi_w_valid, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req"}, axi_aw_req_en, 1'b0);
    chk({tag, "_wvalid"}, axi_w_valid, 1'b0);
    chk({tag, "_wlast"}, axi_w_last, 1'b0);
    chk({tag, "_done"}, burst_done, 1'b0);
    chk({tag, "_data"}, axi_w_data, 128'd0);
    chk({tag, "_count"}, fifo_count, 5'd0);
    chk({tag, "_ready"}, user_wr_ready, 1'b1);
    chk({tag, "_addr"}, axi_aw_addr, 32'h1000);
  endtask

  initial begin
    logic [DW-1:0] got[$];
    int t, v0, bcount;
    axi_w_ready = 1'b1;
    repeat (3) @(negedge axi_clk);
    chk_reset_vals("rst0");
    reset = 1'b1;
    @(negedge axi_clk);

    // 1: three words do not trigger a request; the fourth does
    push_n(3);
    repeat (2) @(negedge axi_clk);
    chk("t1_count3", fifo_count, 5'd3);
    chk("t1_noreq", axi_aw_req_en, 1'b0);
    push_n(1);
    chk("t1_count4", fifo_count, 5'd4);
    chk("t1_req_not_yet", axi_aw_req_en, 1'b0);
    @(negedge axi_clk);
    chk("t1_req", axi_aw_req_en, 1'b1);
    chk("t1_addr", axi_aw_addr, 32'h1000);
    chk("t1_len", axi_aw_burst_len, 8'd3);

    // 2: one burst of 1..4 on consecutive cycles
    wait_wvalid("t2_wvalid_timeout");
    for (int k = 0; k < BL; k++) begin
      chk("t2_beat", axi_w_data, 128'(k + 1));
      chk("t2_last", axi_w_last, (k == BL - 1));
      @(negedge axi_clk);
    end
    chk("t2_done", burst_done, 1'b1);
    chk("t2_count0", fifo_count, 5'd0);

    // 3: fill with the sink stalled, then drain and check ordering
    axi_w_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      user_wr_valid = 1'b1;
      user_wr_data  = DW'(next_val);
      @(negedge axi_clk);
    end
    chk("t3_full_count", fifo_count, 5'd16);
    chk("t3_ready_low", user_wr_ready, 1'b0);
    chk("t3_accepted", next_val, 21);
    user_wr_valid = 1'b0;
    axi_w_ready = 1'b1;
    t = 0;
    while (got.size() < 16 && t < 200) begin
      if (axi_w_valid && axi_w_ready) got.push_back(axi_w_data);
      @(negedge axi_clk);
      t++;
    end
    chk("t3_nbeats", got.size(), 16);
    for (int i = 0; i < got.size(); i++) chk("t3_order", got[i], 128'(5 + i));
    repeat (3) @(negedge axi_clk);

    // 4: five burst addresses including the wrap
    chk("t4_naddr", (aw_log.size() >= 5), 1'b1);
    if (aw_log.size() >= 5) begin
      chk("t4_a0", aw_log[0], 32'h1000);
      chk("t4_a1", aw_log[1], 32'h1040);
      chk("t4_a2", aw_log[2], 32'h1080);
      chk("t4_a3", aw_log[3], 32'h10C0);
      chk("t4_a4", aw_log[4], 32'h1000);
    end

    // 5: alternating w_ready with concurrent pushes
    bcount = 0;
    for (int i = 0; i < 40; i++) begin
      axi_w_ready   = (i % 2 == 0);
      user_wr_valid = ($urandom_range(0, 3) != 0);
      user_wr_data  = DW'(next_val);
      if (axi_w_valid && axi_w_ready) begin
        bcount++;
        chk("t5_last_pos", axi_w_last, (bcount % BL == 0));
      end
      @(negedge axi_clk);
    end
    chk("t5_some_beats", (bcount >= BL), 1'b1);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      axi_w_ready   = ($urandom_range(0, 3) != 0);
      user_wr_valid = ($urandom_range(0, 1) != 0);
      user_wr_data  = {$urandom, $urandom, $urandom, $urandom};
      @(negedge axi_clk);
    end

    // drain to idle
    user_wr_valid = 1'b0;
    axi_w_ready = 1'b1;
    t = 0;
    while ((fifo_count >= 5'd4 || axi_w_valid || axi_aw_req_en) && t < 200) begin
      @(negedge axi_clk);
      t++;
    end
    chk("drain_timeout", (t < 200), 1'b1);

    // 6: reset after two beats of a burst
    push_n(4);
    wait_wvalid("t6_wvalid_timeout");
    @(posedge axi_clk);
    @(posedge axi_clk);
    #3;
    reset = 1'b0;
    #1;
    chk_reset_vals("t6_rst");
    @(negedge axi_clk);
    @(negedge axi_clk);
    reset = 1'b1;
    @(negedge axi_clk);
    v0 = next_val;
    push_n(4);
    t = 0;
    while (!axi_aw_req_en && t < 20) begin
      @(negedge axi_clk);
      t++;
    end
    chk("t6_req", axi_aw_req_en, 1'b1);
    chk("t6_addr", axi_aw_addr, 32'h1000);
    wait_wvalid("t6_wvalid2_timeout");
    for (int k = 0; k < BL; k++) begin
      chk("t6_beat", axi_w_data, 128'(v0 + k));
      @(negedge axi_clk);
    end
    chk("t6_done", burst_done, 1'b1);
    repeat (3) @(negedge axi_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global bound on run time.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
